// File: rtl/debounce_pkg.sv
// Shared definitions for the switch debouncer: per-bit FSM states and counter width.
package debounce_pkg;

    localparam int unsigned CNT_W = 16;

    typedef enum logic {
        IDLE    = 1'b0,
        PENDING = 1'b1
    } db_state_e;

endpackage

// File: rtl/debounce_bit.sv
// One debounced switch bit: 2-flop synchronizer, persistence counter and IDLE/PENDING FSM.
// Edge pulses are built only when SWITCH_DEBOUNCE_EDGE_EN is defined; otherwise tied to zero.
module debounce_bit
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter logic        RESET_VAL       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout,
    output logic rise,
    output logic fall,
    output logic idle
);

    localparam logic [CNT_W-1:0] DEB_CNT = CNT_W'(DEBOUNCE_CYCLES);

    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             dout_q, dout_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    db_state_e        state_q, state_d;

    // Next-state logic for synchronizer, counter, FSM and debounced level.
    always_comb begin
        s1_d    = din;
        s2_d    = s1_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        dout_d  = dout_q;
        case (state_q)
            IDLE: begin
                if (s2_q != dout_q) begin
                    state_d = PENDING;
                    cnt_d   = {{(CNT_W-1){1'b0}}, 1'b1};
                end else begin
                    cnt_d   = {CNT_W{1'b0}};
                end
            end
            PENDING: begin
                if (s2_q == dout_q) begin
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                end else if (cnt_q >= DEB_CNT) begin
                    // Level persisted long enough: accept it; counter never passes DEB_CNT.
                    state_d = IDLE;
                    cnt_d   = {CNT_W{1'b0}};
                    dout_d  = s2_q;
                end else begin
                    cnt_d   = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q    <= RESET_VAL;
            s2_q    <= RESET_VAL;
            dout_q  <= RESET_VAL;
            cnt_q   <= {CNT_W{1'b0}};
            state_q <= IDLE;
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            state_q <= state_d;
        end
    end

    assign dout = dout_q;
    assign idle = (state_q == IDLE);

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    logic accept_s;
    logic rise_q, rise_d;
    logic fall_q, fall_d;

    // Pulse in the same cycle the new level lands on dout.
    always_comb begin
        accept_s = (state_q == PENDING) && (s2_q != dout_q) && (cnt_q >= DEB_CNT);
        rise_d   = accept_s &  s2_q;
        fall_d   = accept_s & ~s2_q;
    end

    // Edge pulse registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign rise = rise_q;
    assign fall = fall_q;
`else
    assign rise = 1'b0;
    assign fall = 1'b0;
`endif

endmodule

// File: rtl/switch_debounce.sv
// Multi-bit switch debouncer: WIDTH independent debounce_bit instances plus a registered
// "all idle" flag. Optional edge pulses controlled by macro SWITCH_DEBOUNCE_EDGE_EN.
module switch_debounce
    import debounce_pkg::*;
#(
    parameter int unsigned          WIDTH           = 3,
    parameter int unsigned          DEBOUNCE_CYCLES = 16,
    parameter logic [WIDTH-1:0]     RESET_VAL       = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic             stable
);

    logic [WIDTH-1:0] idle_s;
    logic             stable_q, stable_d;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        debounce_bit #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .RESET_VAL       (RESET_VAL[i])
        ) u_bit (
            .clk  (clk),
            .rst  (rst),
            .din  (din[i]),
            .dout (dout[i]),
            .rise (rise[i]),
            .fall (fall[i]),
            .idle (idle_s[i])
        );
    end

    // Stable is the AND of all per-bit idle flags.
    always_comb begin
        stable_d = &idle_s;
    end

    // Stable register; reads as stable during reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            stable_q <= 1'b1;
        end else begin
            stable_q <= stable_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: tb/tb_switch_debounce.sv
// Scoreboard bench for switch_debounce (WIDTH=3, DEBOUNCE_CYCLES=4): stimulus pushes expected
// dout/rise/fall events with their edge number; a monitor pops them whenever the outputs change.
module tb_switch_debounce;

`ifdef SWITCH_DEBOUNCE_EDGE_EN
    localparam bit EDGE_EN = 1'b1;
`else
    localparam bit EDGE_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] din;
    logic [2:0] dout, rise, fall;
    logic       stable;

    typedef struct {
        int         cyc;
        logic [2:0] dout;
        logic [2:0] rise;
        logic [2:0] fall;
    } exp_t;

    exp_t       q[$];
    int         cyc = 0;
    int         n_cmp = 0;
    int         n_err = 0;
    bit         mon_en = 1'b0;
    logic [2:0] prev_dout;

    switch_debounce #(
        .WIDTH           (3),
        .DEBOUNCE_CYCLES (4),
        .RESET_VAL       (3'b000)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .din    (din),
        .dout   (dout),
        .rise   (rise),
        .fall   (fall),
        .stable (stable)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s at edge %0d: got %0h expected %0h", name, cyc, act, exp);
        end
    endtask

    // Expect a new dout level (with matching edge pulses) right after edge 'at'.
    task automatic expect_change(input int at, input logic [2:0] old_v, input logic [2:0] new_v);
        exp_t e;
        e.cyc  = at;
        e.dout = new_v;
        e.rise = EDGE_EN ? (new_v & ~old_v) : 3'b000;
        e.fall = EDGE_EN ? (old_v & ~new_v) : 3'b000;
        q.push_back(e);
    endtask

    // Monitor: any dout change or pulse is an output event matched against the queue head.
    always @(negedge clk) begin
        if (mon_en) begin
            if ((dout !== prev_dout) || (rise !== 3'b000) || (fall !== 3'b000)) begin
                if (q.size() == 0) begin
                    chk("unexpected_dout", {29'd0, dout}, {29'd0, prev_dout});
                    chk("unexpected_rise", {29'd0, rise}, 32'd0);
                    chk("unexpected_fall", {29'd0, fall}, 32'd0);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    chk("event_edge", cyc, e.cyc);
                    chk("event_dout", {29'd0, dout}, {29'd0, e.dout});
                    chk("event_rise", {29'd0, rise}, {29'd0, e.rise});
                    chk("event_fall", {29'd0, fall}, {29'd0, e.fall});
                end
            end
            if (q.size() > 0 && q[0].cyc < cyc) begin
                chk("missed_event_edge", cyc, q[0].cyc);
                void'(q.pop_front());
            end
            prev_dout = dout;
        end
    end

    initial begin
        int k;
        rst = 1'b1;
        din = 3'b111;

        // Reset held two edges with all switches high.
        repeat (2) begin
            @(negedge clk);
            chk("reset_dout", {29'd0, dout}, 32'd0);
            chk("reset_rise", {29'd0, rise}, 32'd0);
            chk("reset_fall", {29'd0, fall}, 32'd0);
            chk("reset_stable", {31'd0, stable}, 32'd1);
        end
        rst       = 1'b0;
        prev_dout = 3'b000;
        mon_en    = 1'b1;
        @(negedge clk);
        chk("post_reset_dout", {29'd0, dout}, 32'd0);
        chk("post_reset_stable", {31'd0, stable}, 32'd1);
        din = 3'b000;
        repeat (12) @(negedge clk);
        chk("settled_stable", {31'd0, stable}, 32'd1);

        // Clean rising edge on bit 0, with stable profile around it.
        din = 3'b001;
        k   = cyc + 1;
        expect_change(k + 6, 3'b000, 3'b001);
        for (int e = k; e <= k + 7; e++) begin
            @(negedge clk);
            chk("clean_stable", {31'd0, stable}, (e >= k + 3 && e <= k + 6) ? 32'd0 : 32'd1);
        end
        repeat (4) @(negedge clk);

        // Three-cycle glitch on bit 1 must be swallowed.
        din = 3'b011;
        repeat (3) @(negedge clk);
        din = 3'b001;
        repeat (12) @(negedge clk);
        chk("glitch_dout", {29'd0, dout}, 32'd1);
        chk("glitch_stable", {31'd0, stable}, 32'd1);

        // Bit 0 back low, then two bits together up and down.
        din = 3'b000;
        expect_change(cyc + 7, 3'b001, 3'b000);
        repeat (10) @(negedge clk);
        din = 3'b101;
        expect_change(cyc + 7, 3'b000, 3'b101);
        repeat (10) @(negedge clk);
        chk("simul_dout", {29'd0, dout}, 32'd5);
        din = 3'b000;
        expect_change(cyc + 7, 3'b101, 3'b000);
        repeat (10) @(negedge clk);

        // Reset in the middle of a bit-2 debounce (counter at 2).
        din = 3'b100;
        k   = cyc + 1;
        while (cyc < k + 3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midreset_dout", {29'd0, dout}, 32'd0);
        chk("midreset_rise", {29'd0, rise}, 32'd0);
        chk("midreset_stable", {31'd0, stable}, 32'd1);
        rst = 1'b0;
        expect_change(cyc + 7, 3'b000, 3'b100);
        repeat (6) @(negedge clk);
        chk("midreset_hold", {29'd0, dout}, 32'd0);
        repeat (6) @(negedge clk);
        chk("midreset_final", {29'd0, dout}, 32'd4);
        din = 3'b000;
        expect_change(cyc + 7, 3'b100, 3'b000);
        repeat (12) @(negedge clk);

        chk("queue_drained", q.size(), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
